// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional two-entry
// skid buffer, flush-to-bubble and a saturating stall counter.
module pipe_stage_reg #(
  parameter int unsigned     WIDTH      = 32,
  parameter logic [WIDTH-1:0] BUBBLE_PAT = '0,
  parameter bit              SKID       = 1'b1,
  parameter int unsigned     CNT_W      = 16
) (
  input  logic             i_Clk,
  input  logic             i_reset_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_flush,
  output logic [1:0]       o_occupancy,
  output logic [CNT_W-1:0] o_stall_cnt
);

  // Main entry M drives the outputs; skid entry S catches one extra beat.
  logic             m_valid_q, m_valid_d;
  logic [WIDTH-1:0] m_data_q,  m_data_d;
  logic             s_valid_q, s_valid_d;
  logic [WIDTH-1:0] s_data_q,  s_data_d;
  logic [1:0]       occ_q,     occ_d;
  logic [CNT_W-1:0] stall_q,   stall_d;

  logic accept;
  logic fire;

  // Upstream ready: registered-only source with a skid, else pass-through of downstream ready.
  always_comb begin
    if (SKID) begin
      o_ready = i_reset_n & ~s_valid_q;
    end else begin
      o_ready = i_reset_n & (~m_valid_q | i_ready);
    end
  end

  assign accept = i_valid & o_ready;
  assign fire   = m_valid_q & i_ready;

  // Next-state selection for the held entries, occupancy and stall counter.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;

    if (i_flush) begin
      // An accepted beat in this cycle is swallowed along with held beats.
      m_valid_d = 1'b0;
      m_data_d  = BUBBLE_PAT;
      s_valid_d = 1'b0;
    end else if (SKID) begin
      if (s_valid_q) begin
        if (fire) begin
          m_valid_d = 1'b1;
          m_data_d  = s_data_q;
          s_valid_d = 1'b0;
        end
      end else if (accept && (!m_valid_q || fire)) begin
        m_valid_d = 1'b1;
        m_data_d  = i_data;
      end else if (accept) begin
        s_valid_d = 1'b1;
        s_data_d  = i_data;
      end else if (fire) begin
        m_valid_d = 1'b0;
        m_data_d  = BUBBLE_PAT;
      end
    end else begin
      if (accept) begin
        m_valid_d = 1'b1;
        m_data_d  = i_data;
      end else if (fire) begin
        m_valid_d = 1'b0;
        m_data_d  = BUBBLE_PAT;
      end
    end

    occ_d = 2'({1'b0, m_valid_d}) + 2'({1'b0, s_valid_d});

    stall_d = stall_q;
    if (m_valid_q && !i_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_Clk) begin
    if (!i_reset_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= BUBBLE_PAT;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
      occ_q     <= 2'd0;
      stall_q   <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      occ_q     <= occ_d;
      stall_q   <= stall_d;
    end
  end

  assign o_valid     = m_valid_q;
  assign o_data      = m_data_q;
  assign o_occupancy = occ_q;
  assign o_stall_cnt = stall_q;

endmodule
